// File: rtl/vi_pkg.sv
// ---------------------------------------------------------------------------
// vi_pkg
// Shared types and constants for the video-input frame packer.
//   state_e   : capture FSM states
//   PIX_W     : RGB565 pixel width
//   BEAT_W    : packed write-beat width (two pixels)
//   ADDR_W    : write address width
//   ADDR_INC  : byte address step per beat
//   STAT_W    : width of the optional frame statistics
//   sat_inc() : saturating increment used by the statistics counters
// ---------------------------------------------------------------------------
package vi_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        ACTIVE  = 2'd2,
        FLUSH   = 2'd3
    } state_e;

    localparam int          PIX_W    = 16;
    localparam int          BEAT_W   = 32;
    localparam int          ADDR_W   = 32;
    localparam int unsigned ADDR_INC = 4;
    localparam int          STAT_W   = 12;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/vi_frame_packer_if.sv
// ---------------------------------------------------------------------------
// vi_frame_packer_if
// Write-beat channel from the frame packer to the memory write master.
//   wr_valid : beat valid              (master -> slave)
//   wr_ready : beat accepted           (slave  -> master)
//   wr_addr  : byte address of beat    (master -> slave)
//   wr_data  : {second, first} pixels  (master -> slave)
//   wr_last  : last beat of a burst    (master -> slave)
// ---------------------------------------------------------------------------
interface vi_frame_packer_if;
    import vi_pkg::*;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [BEAT_W-1:0] wr_data;
    logic              wr_last;

    modport master (output wr_valid, wr_addr, wr_data, wr_last, input wr_ready);
    modport slave  (input wr_valid, wr_addr, wr_data, wr_last, output wr_ready);

endinterface

// File: rtl/vi_sync_fifo.sv
// ---------------------------------------------------------------------------
// vi_sync_fifo
// Single-clock first-word-fall-through FIFO. pop_data always shows the head
// entry while empty is low. A push on a full FIFO is accepted only when a pop
// happens in the same cycle.
//   clk, rst_n         : clock, asynchronous active-low reset
//   push, push_data    : write request and data
//   pop                : consume head entry (ignored when empty)
//   pop_data           : head entry
//   full, empty, count : occupancy status
// ---------------------------------------------------------------------------
module vi_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    // NOTE: every variable gets a default at the top of an always_comb so no path leaves it unassigned and infers a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; entries are only observable after a push, and leaving it unreset keeps it in plain RAM cells.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/vi_frame_packer.sv
// ---------------------------------------------------------------------------
// vi_frame_packer
// Packs RGB565 pixel pairs from the video-input stream into 32-bit words,
// buffers them in a FWFT FIFO and emits address-tagged write beats in bursts.
//   clk, rst_n              : clock, asynchronous active-low reset
//   cfg_enable              : capture enable, sampled at frame start
//   cfg_base_addr           : frame buffer byte address (word aligned)
//   vin_vs, vin_de, vin_data: video stream (vsync, pixel valid, pixel)
//   wr_if (master)          : write-beat channel
//   frame_done              : one-cycle pulse once a frame has drained
//   overflow                : sticky, a word was dropped on a full FIFO
//   stat_lines, stat_pixels : last frame's line count / pixels per line
// Optional feature macro: VI_FRAME_STATS_EN (statistics counters); without
// it the statistics outputs are tied to zero.
// ---------------------------------------------------------------------------
module vi_frame_packer
    import vi_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int BURST_LEN  = 8,
    parameter int VS_POL     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_enable,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic              vin_vs,
    input  logic              vin_de,
    input  logic [PIX_W-1:0]  vin_data,
    vi_frame_packer_if.master wr_if,
    output logic              frame_done,
    output logic              overflow,
    output logic [STAT_W-1:0] stat_lines,
    output logic [STAT_W-1:0] stat_pixels
);

    localparam int   CW     = $clog2(FIFO_DEPTH) + 1;
    localparam int   BCW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic VS_ACT = (VS_POL != 0);

    state_e            state_q, state_d;
    logic              vs_q;
    logic              half_valid_q, half_valid_d;
    logic [PIX_W-1:0]  half_q, half_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BCW-1:0]    burst_q, burst_d;
    logic              overflow_q, overflow_d;

    logic              fs, push, pop, done_c;
    logic              fifo_full, fifo_empty;
    logic [BEAT_W-1:0] push_data, fifo_head;
    logic [CW-1:0]     fifo_count;

    // Frame start: first cycle vsync sits at its active level.
    assign fs  = (vin_vs == VS_ACT) && (vs_q != VS_ACT);
    assign pop = !fifo_empty && wr_if.wr_ready;

    vi_sync_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d      = state_q;
        half_valid_d = half_valid_q;
        half_d       = half_q;
        addr_d       = addr_q;
        burst_d      = burst_q;
        overflow_d   = overflow_q;
        push         = 1'b0;
        push_data    = '0;
        done_c       = 1'b0;

        if (pop) begin
            addr_d  = addr_q + ADDR_W'(ADDR_INC);
            burst_d = (burst_q == BCW'(BURST_LEN - 1)) ? '0 : burst_q + BCW'(1);
        end

        case (state_q)
            IDLE: begin
                overflow_d = 1'b0;
                if (cfg_enable) state_d = WAIT_VS;
            end
            WAIT_VS: begin
                if (!cfg_enable) begin
                    state_d = IDLE;
                end else if (fs) begin
                    addr_d  = cfg_base_addr;
                    burst_d = '0;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                // fs has priority: a de pulse on the same cycle is dropped.
                if (fs) begin
                    state_d      = FLUSH;
                    push         = half_valid_q;
                    push_data    = {{PIX_W{1'b0}}, half_q};
                    half_valid_d = 1'b0;
                end else if (vin_de) begin
                    if (half_valid_q) begin
                        push         = 1'b1;
                        push_data    = {vin_data, half_q};
                        half_valid_d = 1'b0;
                    end else begin
                        half_d       = vin_data;
                        half_valid_d = 1'b1;
                    end
                end
            end
            FLUSH: begin
                // Empty FIFO in FWFT mode means no beat is still pending.
                if (fifo_empty) begin
                    done_c  = 1'b1;
                    addr_d  = cfg_base_addr;
                    burst_d = '0;
                    state_d = cfg_enable ? ACTIVE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push && fifo_full && !pop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vs_q         <= ~VS_ACT;
            half_valid_q <= 1'b0;
            half_q       <= '0;
            addr_q       <= '0;
            burst_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            vs_q         <= vin_vs;
            half_valid_q <= half_valid_d;
            half_q       <= half_d;
            addr_q       <= addr_d;
            burst_q      <= burst_d;
            overflow_q   <= overflow_d;
        end
    end

    assign wr_if.wr_valid = !fifo_empty;
    assign wr_if.wr_addr  = addr_q;
    assign wr_if.wr_data  = fifo_empty ? '0 : fifo_head;
    assign wr_if.wr_last  = !fifo_empty &&
                            ((burst_q == BCW'(BURST_LEN - 1)) ||
                             (state_q == FLUSH && fifo_count == CW'(1)));
    assign frame_done     = done_c;
    assign overflow       = overflow_q;

`ifdef VI_FRAME_STATS_EN
    logic              de_q, de_d;
    logic [STAT_W-1:0] pix_q, pix_d, run_q, run_d;
    logic [STAT_W-1:0] stat_lines_q, stat_lines_d, stat_pixels_q, stat_pixels_d;

    always_comb begin
        de_d          = (state_q == ACTIVE) && vin_de && !fs;
        pix_d         = pix_q;
        run_d         = run_q;
        stat_lines_d  = stat_lines_q;
        stat_pixels_d = stat_pixels_q;
        if (fs) begin
            if (state_q == ACTIVE) begin
                stat_lines_d  = run_q;
                stat_pixels_d = pix_q;
            end
            pix_d = '0;
            run_d = '0;
        end else if (de_d) begin
            // A rising edge of de opens a new line; pix restarts at one.
            if (!de_q) begin
                run_d = sat_inc(run_q);
                pix_d = STAT_W'(1);
            end else begin
                pix_d = sat_inc(pix_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_q          <= 1'b0;
            pix_q         <= '0;
            run_q         <= '0;
            stat_lines_q  <= '0;
            stat_pixels_q <= '0;
        end else begin
            de_q          <= de_d;
            pix_q         <= pix_d;
            run_q         <= run_d;
            stat_lines_q  <= stat_lines_d;
            stat_pixels_q <= stat_pixels_d;
        end
    end

    assign stat_lines  = stat_lines_q;
    assign stat_pixels = stat_pixels_q;
`else
    assign stat_lines  = '0;
    assign stat_pixels = '0;
`endif

endmodule

// File: tb/tb_vi_frame_packer.sv
// ---------------------------------------------------------------------------
// tb_vi_frame_packer
// Self-checking bench for vi_frame_packer. Each frame's pixels are generated
// up front; a frame-level model turns them into the expected beat list
// (pairs packed {second, first}, odd tail zero-padded, base + 4*k addresses,
// burst-end and short-final-burst wr_last). A monitor compares every
// accepted beat against that list and checks beats hold while stalled.
// ---------------------------------------------------------------------------
module tb_vi_frame_packer;
    import vi_pkg::*;

    localparam int TB_BURST = 8;
    localparam int TB_DEPTH = 16;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        cfg_enable;
    logic [31:0] cfg_base_addr;
    logic        vin_vs;
    logic        vin_de;
    logic [15:0] vin_data;
    logic        frame_done;
    logic        overflow;
    logic [11:0] stat_lines;
    logic [11:0] stat_pixels;

    vi_frame_packer_if wr_if ();

    vi_frame_packer #(
        .FIFO_DEPTH (TB_DEPTH),
        .BURST_LEN  (TB_BURST),
        .VS_POL     (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_enable    (cfg_enable),
        .cfg_base_addr (cfg_base_addr),
        .vin_vs        (vin_vs),
        .vin_de        (vin_de),
        .vin_data      (vin_data),
        .wr_if         (wr_if),
        .frame_done    (frame_done),
        .overflow      (overflow),
        .stat_lines    (stat_lines),
        .stat_pixels   (stat_pixels)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          beats_seen = 0;
    int          done_cnt = 0;
    int          ready_mode = 0;   // 0: always 1, 1: toggle, 2: random, 3: held 0
    beat_t       exp_q[$];
    logic [15:0] frame_pix[$];
    logic [31:0] cur_base;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, want, $time);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        wr_if.wr_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       wr_if.wr_ready = 1'b1;
                1:       wr_if.wr_ready = ~wr_if.wr_ready;
                2:       wr_if.wr_ready = 1'($urandom_range(0, 1));
                default: wr_if.wr_ready = 1'b0;
            endcase
        end
    end

    // Beat monitor, sampled on the falling edge.
    logic        held;
    logic [31:0] held_addr, held_data;
    initial held = 1'b0;
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("stall_valid", wr_if.wr_valid, 1);
                check("stall_addr", wr_if.wr_addr, held_addr);
                check("stall_data", wr_if.wr_data, held_data);
            end
            held = 1'b0;
            if (wr_if.wr_valid && !wr_if.wr_ready) begin
                held      = 1'b1;
                held_addr = wr_if.wr_addr;
                held_data = wr_if.wr_data;
            end
            if (wr_if.wr_valid && wr_if.wr_ready) begin
                beats_seen++;
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("beat_addr", wr_if.wr_addr, e.addr);
                    check("beat_data", wr_if.wr_data, e.data);
                    check("beat_last", wr_if.wr_last, e.last);
                end
            end
            if (frame_done) done_cnt++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 500 && wr_if.wr_valid; i++) tick();
        check("drain", wr_if.wr_valid, 0);
    endtask

    // Frame boundary; optionally drive a de pulse on the fs cycle (must be ignored).
    task automatic vs_pulse(input bit de_at_fs = 1'b0);
        vin_vs   = 1'b1;
        vin_de   = de_at_fs;
        vin_data = 16'hDEAD;
        tick();
        vin_de = 1'b0;
        tick();
        vin_vs = 1'b0;
        wait_drain();
        tick(3);
    endtask

    task automatic plan_frame(input int lines, input int ppl);
        frame_pix.delete();
        for (int i = 0; i < lines * ppl; i++) frame_pix.push_back(16'($urandom));
    endtask

    // Frame-level model: all accepted words of the frame, in order.
    task automatic model_frame(input logic [31:0] base, input int keep);
        logic [31:0] words[$];
        int          n;
        bit          odd;
        beat_t       b;
        n   = frame_pix.size();
        odd = (n % 2) == 1;
        for (int i = 0; i < n; i += 2) begin
            if (i + 1 < n) words.push_back({frame_pix[i+1], frame_pix[i]});
            else           words.push_back({16'h0000, frame_pix[i]});
        end
        if (words.size() > keep) n = keep;
        else                     n = words.size();
        for (int k = 0; k < n; k++) begin
            b.addr = base + 32'(4 * k);
            b.data = words[k];
            b.last = ((k % TB_BURST) == TB_BURST - 1) || (odd && k == n - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic drive_line(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            vin_de   = 1'b1;
            vin_data = frame_pix[first + i];
            tick();
        end
        vin_de   = 1'b0;
        vin_data = 16'($urandom);
        tick(4);
    endtask

    task automatic drive_frame(input int lines, input int ppl);
        for (int l = 0; l < lines; l++) drive_line(l * ppl, ppl);
    endtask

    initial begin
        int d0, b0, lines, ppl;
        logic [31:0] nb;

        rst_n = 1'b0; cfg_enable = 1'b0; cfg_base_addr = '0;
        vin_vs = 1'b0; vin_de = 1'b0; vin_data = '0;
        tick(3);
        check("rst_valid", wr_if.wr_valid, 0);
        check("rst_addr", wr_if.wr_addr, 0);
        check("rst_data", wr_if.wr_data, 0);
        check("rst_last", wr_if.wr_last, 0);
        check("rst_done", frame_done, 0);
        check("rst_ovf", overflow, 0);
        check("rst_stats", {stat_lines, stat_pixels}, 0);
        rst_n = 1'b1;
        tick(2);

        // 1: 4 x 16 frame, always ready.
        cur_base = 32'h8000_0000; cfg_base_addr = cur_base; cfg_enable = 1'b1;
        tick(3);
        vs_pulse();
        plan_frame(4, 16); model_frame(cur_base, 1000);
        b0 = beats_seen; d0 = done_cnt;
        drive_frame(4, 16);
        wait_drain();
        vs_pulse();
        check("t1_beats", beats_seen - b0, 32);
        check("t1_done", done_cnt - d0, 1);
        check("t1_left", exp_q.size(), 0);
`ifdef VI_FRAME_STATS_EN
        check("t1_stat_lines", stat_lines, 4);
        check("t1_stat_pixels", stat_pixels, 16);
`endif

        // 2: odd line, zero-padded tail at the next fs, de on the fs cycle.
        frame_pix = '{16'h1111, 16'h2222, 16'h3333};
        model_frame(cur_base, 1000);
        b0 = beats_seen; d0 = done_cnt;
        drive_line(0, 3);
        wait_drain();
        check("t2_first", beats_seen - b0, 1);
        vs_pulse(1'b1);
        check("t2_beats", beats_seen - b0, 2);
        check("t2_done", done_cnt - d0, 1);
        check("t2_left", exp_q.size(), 0);

        // 3: stalled 40-pixel line overflows the FIFO; 16 words survive.
        ready_mode = 3;
        tick(2);
        plan_frame(1, 40); model_frame(cur_base, TB_DEPTH);
        b0 = beats_seen;
        drive_frame(1, 40);
        check("t3_ovf", overflow, 1);
        ready_mode = 0;
        wait_drain();
        vs_pulse();
        check("t3_beats", beats_seen - b0, TB_DEPTH);
        check("t3_left", exp_q.size(), 0);
        check("t3_ovf_sticky", overflow, 1);

        // 4: toggling then random ready, random frame shapes and bases.
        for (int f = 0; f < 5; f++) begin
            ready_mode = (f == 0) ? 1 : 2;
            lines = $urandom_range(1, 4);
            ppl   = $urandom_range(1, 20);
            plan_frame(lines, ppl); model_frame(cur_base, 1000);
            b0 = beats_seen; d0 = done_cnt;
            drive_frame(lines, ppl);
            wait_drain();
            nb = (f == 2) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            cfg_base_addr = nb;
            vs_pulse();
            cur_base = nb;
            check("t4_beats", beats_seen - b0, (lines * ppl + 1) / 2);
            check("t4_done", done_cnt - d0, 1);
            check("t4_left", exp_q.size(), 0);
        end

        // 5: enable dropped mid-frame; frame completes then capture stops.
        ready_mode = 0;
        plan_frame(2, 10); model_frame(cur_base, 1000);
        d0 = done_cnt;
        drive_line(0, 10);
        cfg_enable = 1'b0;
        drive_line(10, 10);
        wait_drain();
        vs_pulse();
        check("t5_done", done_cnt - d0, 1);
        check("t5_left", exp_q.size(), 0);
        check("t5_ovf_clr", overflow, 0);
        b0 = beats_seen; d0 = done_cnt;
        plan_frame(1, 12);
        drive_line(0, 12);
        vs_pulse();
        drive_line(0, 12);
        vs_pulse();
        check("t5_idle_beats", beats_seen - b0, 0);
        check("t5_idle_done", done_cnt - d0, 0);

        // 6: reset mid-burst, then a clean frame at the base address.
        cur_base = 32'h1000_0040; cfg_base_addr = cur_base; cfg_enable = 1'b1;
        tick(3);
        vs_pulse();
        ready_mode = 3;
        tick(2);
        plan_frame(1, 10);
        drive_line(0, 10);
        check("t6_pending", wr_if.wr_valid, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", wr_if.wr_valid, 0);
        check("t6_rst_addr", wr_if.wr_addr, 0);
        exp_q.delete();
        tick(2);
        rst_n = 1'b1;
        ready_mode = 0;
        tick(3);
        vs_pulse();
        plan_frame(2, 8); model_frame(cur_base, 1000);
        b0 = beats_seen; d0 = done_cnt;
        drive_frame(2, 8);
        wait_drain();
        vs_pulse();
        check("t6_beats", beats_seen - b0, 8);
        check("t6_done", done_cnt - d0, 1);
        check("t6_left", exp_q.size(), 0);

        tick(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
